// File: rtl/jt12_timer_pkg.sv
// Shared constants for the JT12 Timer A / Timer B block: default geometry
// of the slot counter and both timers, plus the bit layout of register 0x27.
package jt12_timer_pkg;

  // Internal clocks per sample tick (one FM sample = 24 operator slots)
  localparam int JT12_TICK_DIV = 24;
  // Timer A counter width
  localparam int JT12_TA_W     = 10;
  // Timer B counter width
  localparam int JT12_TB_W     = 8;
  // Sample ticks per Timer B increment
  localparam int JT12_TB_PRESC = 16;

  // Register 0x27 bit positions
  localparam int REG27_LOAD_A   = 0;
  localparam int REG27_LOAD_B   = 1;
  localparam int REG27_EN_IRQ_A = 2;
  localparam int REG27_EN_IRQ_B = 3;
  localparam int REG27_CLR_A    = 4;
  localparam int REG27_CLR_B    = 5;

  // Width of a prescaler that counts 0..presc-1; a divide-by-one keeps a
  // single bit that never leaves zero.
  function automatic int presc_width(input int presc);
    return (presc > 1) ? $clog2(presc) : 1;
  endfunction

endpackage

// File: rtl/jt12_timer_cnt.sv
// One programmable overflow timer: run-enable edge detector, optional
// tick prescaler, up-counter with reload on overflow, one-clk overflow
// pulse and a sticky status flag where a set beats a same-clk clear.
module jt12_timer_cnt
  import jt12_timer_pkg::*;
#(
  parameter int W     = 10,
  parameter int PRESC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_i,
  input  logic [W-1:0] value_i,
  input  logic         load_i,
  input  logic         en_irq_i,
  input  logic         clr_flag_i,
  output logic         overflow_o,
  output logic         flag_o
);

  localparam int            PW         = presc_width(PRESC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [W-1:0]  CNT_ONES   = {W{1'b1}};
  localparam logic [W-1:0]  CNT_ONE    = W'(1);

  logic          load_dly_q;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ovf_q, ovf_d;
  logic          flag_q, flag_d;

  logic rise_s;   // run enable just went high: (re)load the counter
  logic step_s;   // running and a sample tick is present
  logic hit_s;    // prescaler says the counter advances on this tick
  logic wrap_s;   // counter is all-ones at an advance: overflow

  // Decode load edge, tick gating and overflow condition
  always_comb begin
    rise_s = load_i & ~load_dly_q;
    step_s = load_i & tick_i;
    hit_s  = step_s & (presc_q == PRESC_LAST);
    // a fresh load on a tick takes priority over the increment
    wrap_s = hit_s & (cnt_q == CNT_ONES) & ~rise_s;
  end

  // Next counter and prescaler values
  always_comb begin
    cnt_d   = cnt_q;
    presc_d = presc_q;
    if (rise_s) begin
      cnt_d   = value_i;
      presc_d = PRESC_ZERO;
    end else if (step_s) begin
      if (hit_s) begin
        presc_d = PRESC_ZERO;
        // reload samples value_i now, so mid-count writes hit the next period
        if (cnt_q == CNT_ONES) begin
          cnt_d = value_i;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end else begin
      // frozen: load low or no tick this clk
      cnt_d   = cnt_q;
      presc_d = presc_q;
    end
  end

  // Overflow pulse and sticky flag with set-over-clear priority
  always_comb begin
    ovf_d  = wrap_s;
    flag_d = flag_q;
    if (wrap_s & en_irq_i) begin
      flag_d = 1'b1;
    end else if (clr_flag_i) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_dly_q <= 1'b0;
      cnt_q      <= {W{1'b0}};
      presc_q    <= PRESC_ZERO;
      ovf_q      <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      load_dly_q <= load_i;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      ovf_q      <= ovf_d;
      flag_q     <= flag_d;
    end
  end

  assign overflow_o = ovf_q;
  assign flag_o     = flag_q;

endmodule

// File: rtl/jt12_timer.sv
// JT12 Timer A / Timer B block: slot counter generating the per-sample
// tick, two overflow timers, status flags and the active-low IRQ line.
module jt12_timer
  import jt12_timer_pkg::*;
#(
  parameter int TICK_DIV = JT12_TICK_DIV,
  parameter int TA_W     = JT12_TA_W,
  parameter int TB_W     = JT12_TB_W,
  parameter int TB_PRESC = JT12_TB_PRESC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TA_W-1:0] value_a,
  input  logic [TB_W-1:0] value_b,
  input  logic            load_a,
  input  logic            load_b,
  input  logic            en_irq_a,
  input  logic            en_irq_b,
  input  logic            clr_flag_a,
  input  logic            clr_flag_b,
  output logic            zero,
  output logic            flag_a,
  output logic            flag_b,
  output logic            overflow_a,
  output logic            irq_n
);

  localparam int            CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q, zero_d;
  logic          unused_ovf_b_s;   // Timer B overflow pulse has no consumer

  // Slot counter wrap and look-ahead so zero is high while cnt is last slot
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    zero_d = (cnt_d == CNT_LAST);
  end

  // Slot counter and registered sample tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_ZERO;
      zero_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;

  jt12_timer_cnt #(
    .W     (TA_W),
    .PRESC (1)
  ) u_tmr_a (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (zero_q),
    .value_i    (value_a),
    .load_i     (load_a),
    .en_irq_i   (en_irq_a),
    .clr_flag_i (clr_flag_a),
    .overflow_o (overflow_a),
    .flag_o     (flag_a)
  );

  jt12_timer_cnt #(
    .W     (TB_W),
    .PRESC (TB_PRESC)
  ) u_tmr_b (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (zero_q),
    .value_i    (value_b),
    .load_i     (load_b),
    .en_irq_i   (en_irq_b),
    .clr_flag_i (clr_flag_b),
    .overflow_o (unused_ovf_b_s),
    .flag_o     (flag_b)
  );

  // IRQ follows the flags without a register stage
  assign irq_n = ~(flag_a | flag_b);

endmodule

// File: tb/tb_jt12_timer.sv
// Self-checking bench for jt12_timer. Expected event times (tick pulses,
// overflow pulses, flag sets) are computed from the sample-tick schedule
// and queued; the DUT's events are popped and compared as they appear.
module tb_jt12_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] value_a;
  logic [7:0] value_b;
  logic       load_a, load_b, en_irq_a, en_irq_b, clr_flag_a, clr_flag_b;
  logic       zero, flag_a, flag_b, overflow_a, irq_n;

  int tests = 0;
  int fails = 0;
  int ecnt;        // posedges since last reset release
  int exp_q[$];    // scoreboard of expected event cycles

  jt12_timer dut (
    .clk        (clk),
    .rst        (rst),
    .value_a    (value_a),
    .value_b    (value_b),
    .load_a     (load_a),
    .load_b     (load_b),
    .en_irq_a   (en_irq_a),
    .en_irq_b   (en_irq_b),
    .clr_flag_a (clr_flag_a),
    .clr_flag_b (clr_flag_b),
    .zero       (zero),
    .flag_a     (flag_a),
    .flag_b     (flag_b),
    .overflow_a (overflow_a),
    .irq_n      (irq_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  // first cycle >= e in which the tick (zero) is high: cycles 23, 47, ...
  function automatic int first_tick(input int e);
    return e + ((23 - (e % 24) + 24) % 24);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    value_a = 10'd0; value_b = 8'd0;
    load_a = 1'b0; load_b = 1'b0; en_irq_a = 1'b0; en_irq_b = 1'b0;
    clr_flag_a = 1'b0; clr_flag_b = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (zero !== 1'b0)       begin fails++; $display("FAIL reset_zero: got %b want 0", zero); end
    tests++; if (flag_a !== 1'b0)     begin fails++; $display("FAIL reset_flag_a: got %b want 0", flag_a); end
    tests++; if (flag_b !== 1'b0)     begin fails++; $display("FAIL reset_flag_b: got %b want 0", flag_b); end
    tests++; if (overflow_a !== 1'b0) begin fails++; $display("FAIL reset_ovf_a: got %b want 0", overflow_a); end
    tests++; if (irq_n !== 1'b1)      begin fails++; $display("FAIL reset_irq_n: got %b want 1", irq_n); end
    rst = 1'b0;
  endtask

  task automatic test_idle;
    int e;
    exp_q.delete();
    for (int k = 23; k < 120; k += 24) exp_q.push_back(k);
    while (ecnt < 120) begin
      @(negedge clk);
      if (zero === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL idle_zero_extra: got pulse at %0d want none", ecnt);
        end else begin
          e = exp_q.pop_front();
          if (ecnt !== e) begin fails++; $display("FAIL idle_zero_time: got %0d want %0d", ecnt, e); end
        end
      end
      if (exp_q.size() > 0 && ecnt > exp_q[0]) begin
        tests++; fails++;
        $display("FAIL idle_zero_missing: got none want pulse at %0d", exp_q[0]);
        void'(exp_q.pop_front());
      end
      tests++;
      if (flag_a !== 1'b0 || flag_b !== 1'b0 || overflow_a !== 1'b0 || irq_n !== 1'b1) begin
        fails++;
        $display("FAIL idle_quiet: got fa=%b fb=%b ovf=%b irq_n=%b want 0 0 0 1 at %0d",
                 flag_a, flag_b, overflow_a, irq_n, ecnt);
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL idle_zero_left: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_timer_a;
    int e, t1, ovf1, stop;
    @(negedge clk);
    value_a = 10'd1020; en_irq_a = 1'b1; load_a = 1'b1;
    t1   = first_tick(ecnt + 1);
    ovf1 = t1 + 3 * 24 + 1;
    exp_q.delete();
    exp_q.push_back(ovf1);
    exp_q.push_back(ovf1 + 4 * 24);
    stop = ovf1 + 4 * 24 + 10;
    while (ecnt < stop) begin
      @(negedge clk);
      clr_flag_a = 1'b0;
      if (overflow_a === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL a_ovf_extra: got pulse at %0d want none", ecnt);
        end else begin
          e = exp_q.pop_front();
          if (ecnt !== e) begin fails++; $display("FAIL a_ovf_time: got %0d want %0d", ecnt, e); end
        end
      end
      if (exp_q.size() > 0 && ecnt > exp_q[0]) begin
        tests++; fails++;
        $display("FAIL a_ovf_missing: got none want pulse at %0d", exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (ecnt == ovf1 || ecnt == ovf1 + 96) begin
        tests++; if (flag_a !== 1'b1) begin fails++; $display("FAIL a_flag_set: got %b want 1 at %0d", flag_a, ecnt); end
        tests++; if (irq_n !== 1'b0)  begin fails++; $display("FAIL a_irq_low: got %b want 0 at %0d", irq_n, ecnt); end
      end
      if (ecnt == ovf1 + 4) begin
        tests++; if (flag_a !== 1'b0) begin fails++; $display("FAIL a_flag_clr: got %b want 0", flag_a); end
        tests++; if (irq_n !== 1'b1)  begin fails++; $display("FAIL a_irq_rel: got %b want 1", irq_n); end
      end
      if (ecnt == ovf1 + 3) clr_flag_a = 1'b1;
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL a_ovf_left: got %0d pending want 0", exp_q.size()); end
    load_a = 1'b0; clr_flag_a = 1'b1;
    @(negedge clk);
    clr_flag_a = 1'b0;
    tests++; if (flag_a !== 1'b0) begin fails++; $display("FAIL a_flag_final_clr: got %b want 0", flag_a); end
  endtask

  task automatic test_timer_b;
    int e, t1, fset;
    logic prev;
    @(negedge clk);
    value_b = 8'd254; en_irq_b = 1'b1; load_b = 1'b1;
    t1   = first_tick(ecnt + 1);
    fset = t1 + 31 * 24 + 1;
    exp_q.delete();
    exp_q.push_back(fset);
    prev = flag_b;
    while (ecnt < fset + 48) begin
      @(negedge clk);
      if (flag_b === 1'b1 && prev === 1'b0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL b_flag_extra: got set at %0d want none", ecnt);
        end else begin
          e = exp_q.pop_front();
          if (ecnt !== e) begin fails++; $display("FAIL b_flag_time: got %0d want %0d", ecnt, e); end
        end
      end
      if (exp_q.size() > 0 && ecnt > exp_q[0]) begin
        tests++; fails++;
        $display("FAIL b_flag_missing: got none want set at %0d", exp_q[0]);
        void'(exp_q.pop_front());
      end
      prev = flag_b;
    end
    tests++; if (irq_n !== 1'b0) begin fails++; $display("FAIL b_irq_low: got %b want 0", irq_n); end
    // 20 ticks after the overflow: one prescaler round done, cnt_b = 255
    while (ecnt < fset + 20 * 24) @(negedge clk);
    load_b = 1'b0;
    tests++; if (dut.u_tmr_b.cnt_q !== 8'd255) begin fails++; $display("FAIL b_cnt_at_freeze: got %0d want 255", dut.u_tmr_b.cnt_q); end
    repeat (100 * 24) @(negedge clk);
    tests++; if (dut.u_tmr_b.cnt_q !== 8'd255) begin fails++; $display("FAIL b_cnt_frozen: got %0d want 255", dut.u_tmr_b.cnt_q); end
    en_irq_b = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (flag_b !== 1'b1) begin fails++; $display("FAIL b_flag_sticky: got %b want 1", flag_b); end
    clr_flag_b = 1'b1;
    @(negedge clk);
    clr_flag_b = 1'b0;
    tests++; if (flag_b !== 1'b0) begin fails++; $display("FAIL b_flag_clr: got %b want 0", flag_b); end
    tests++; if (irq_n !== 1'b1)  begin fails++; $display("FAIL b_irq_rel: got %b want 1", irq_n); end
  endtask

  task automatic test_no_irq_a;
    int e, t1, stop;
    @(negedge clk);
    value_a = 10'd1022; en_irq_a = 1'b0; load_a = 1'b1;
    t1 = first_tick(ecnt + 1);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(t1 + 24 + 1 + k * 48);
    stop = t1 + 25 + 3 * 48 + 10;
    while (ecnt < stop) begin
      @(negedge clk);
      if (overflow_a === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL noirq_ovf_extra: got pulse at %0d want none", ecnt);
        end else begin
          e = exp_q.pop_front();
          if (ecnt !== e) begin fails++; $display("FAIL noirq_ovf_time: got %0d want %0d", ecnt, e); end
        end
      end
      if (exp_q.size() > 0 && ecnt > exp_q[0]) begin
        tests++; fails++;
        $display("FAIL noirq_ovf_missing: got none want pulse at %0d", exp_q[0]);
        void'(exp_q.pop_front());
      end
      tests++; if (flag_a !== 1'b0) begin fails++; $display("FAIL noirq_flag: got %b want 0 at %0d", flag_a, ecnt); end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL noirq_ovf_left: got %0d pending want 0", exp_q.size()); end
    load_a = 1'b0;
  endtask

  task automatic test_set_wins;
    int t1, ovf;
    @(negedge clk);
    value_a = 10'd1022; en_irq_a = 1'b1; load_a = 1'b1;
    t1  = first_tick(ecnt + 1);
    ovf = t1 + 25;
    while (ecnt < ovf - 1) @(negedge clk);
    clr_flag_a = 1'b1;   // coincides with the set on the overflow edge
    @(negedge clk);
    clr_flag_a = 1'b0;
    tests++; if (overflow_a !== 1'b1) begin fails++; $display("FAIL setwins_ovf: got %b want 1 at %0d", overflow_a, ecnt); end
    tests++; if (flag_a !== 1'b1)     begin fails++; $display("FAIL setwins_flag: got %b want 1", flag_a); end
    load_a = 1'b0;
    clr_flag_a = 1'b1;
    @(negedge clk);
    clr_flag_a = 1'b0;
    tests++; if (flag_a !== 1'b0) begin fails++; $display("FAIL setwins_clr: got %b want 0", flag_a); end
  endtask

  task automatic test_reset_mid;
    int e, n, ovf;
    @(negedge clk);
    value_a = 10'd1022; en_irq_a = 1'b1; load_a = 1'b1;
    n = 0;
    while (flag_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    tests++; if (flag_a !== 1'b1) begin fails++; $display("FAIL rstmid_setup: got %b want 1", flag_a); end
    value_a = 10'd1000;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (flag_a !== 1'b0)     begin fails++; $display("FAIL rstmid_flag: got %b want 0", flag_a); end
    tests++; if (irq_n !== 1'b1)      begin fails++; $display("FAIL rstmid_irq_n: got %b want 1", irq_n); end
    tests++; if (zero !== 1'b0)       begin fails++; $display("FAIL rstmid_zero: got %b want 0", zero); end
    tests++; if (dut.u_tmr_a.cnt_q !== 10'd0) begin fails++; $display("FAIL rstmid_cnt_a: got %0d want 0", dut.u_tmr_a.cnt_q); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++; if (overflow_a !== 1'b0) begin fails++; $display("FAIL rstmid_ovf: got %b want 0", overflow_a); end
    end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (dut.u_tmr_a.cnt_q !== 10'd1000) begin fails++; $display("FAIL rstmid_reload: got %0d want 1000", dut.u_tmr_a.cnt_q); end
    ovf = first_tick(1) + 23 * 24 + 1;
    exp_q.delete();
    exp_q.push_back(ovf);
    while (ecnt < ovf + 10) begin
      @(negedge clk);
      if (overflow_a === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rstmid_ovf_extra: got pulse at %0d want none", ecnt);
        end else begin
          e = exp_q.pop_front();
          if (ecnt !== e) begin fails++; $display("FAIL rstmid_ovf_time: got %0d want %0d", ecnt, e); end
          if (flag_a !== 1'b1) begin fails++; $display("FAIL rstmid_flag_set: got %b want 1", flag_a); end
        end
      end
      if (exp_q.size() > 0 && ecnt > exp_q[0]) begin
        tests++; fails++;
        $display("FAIL rstmid_ovf_missing: got none want pulse at %0d", exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rstmid_ovf_left: got %0d pending want 0", exp_q.size()); end
    load_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_timer_a();
    test_timer_b();
    test_no_irq_a();
    test_set_wins();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    tests++; fails++;
    $display("FAIL watchdog: got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
